// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the MIPS instruction encoder: format codes, field positions,
// special opcodes, FSM states and the R/I/J packing function.
package instr_enc_pkg;

   typedef enum logic [1:0] {
      FMT_R   = 2'b00,
      FMT_I   = 2'b01,
      FMT_J   = 2'b10,
      FMT_BAD = 2'b11
   } fmt_e;

   localparam int unsigned OP_MSB  = 31;
   localparam int unsigned OP_LSB  = 26;
   localparam int unsigned RS_MSB  = 25;
   localparam int unsigned RS_LSB  = 21;
   localparam int unsigned RT_MSB  = 20;
   localparam int unsigned RT_LSB  = 16;
   localparam int unsigned RD_MSB  = 15;
   localparam int unsigned RD_LSB  = 11;
   localparam int unsigned SH_MSB  = 10;
   localparam int unsigned SH_LSB  = 6;
   localparam int unsigned FN_MSB  = 5;
   localparam int unsigned FN_LSB  = 0;
   localparam int unsigned IMM_MSB = 15;
   localparam int unsigned IMM_LSB = 0;
   localparam int unsigned TGT_MSB = 25;
   localparam int unsigned TGT_LSB = 0;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;

   typedef enum logic [1:0] {
      StIdle,
      StStream,
      StDone
   } state_e;

   function automatic logic [31:0] pack_word(input fmt_e fmt, input logic [5:0] op,
                                             input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [4:0] shamt,
                                             input logic [5:0] funct, input logic [15:0] imm,
                                             input logic [25:0] target);
      logic [31:0] w;
      w = '0;
      w[OP_MSB:OP_LSB] = op;
      unique case (fmt)
         FMT_R: begin
            w[RS_MSB:RS_LSB] = rs;
            w[RT_MSB:RT_LSB] = rt;
            w[RD_MSB:RD_LSB] = rd;
            w[SH_MSB:SH_LSB] = shamt;
            w[FN_MSB:FN_LSB] = funct;
         end
         FMT_I: begin
            w[RS_MSB:RS_LSB]   = rs;
            w[RT_MSB:RT_LSB]   = rt;
            w[IMM_MSB:IMM_LSB] = imm;
         end
         FMT_J:   w[TGT_MSB:TGT_LSB] = target;
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-input handshake and instruction-memory write bus of the instruction encoder.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W = 8
) ();
   import instr_enc_pkg::*;

   logic              in_valid;
   logic              in_ready;
   fmt_e              fmt;
   logic [5:0]        op;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [4:0]        shamt;
   logic [5:0]        funct;
   logic [15:0]       imm;
   logic [25:0]       target;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ready;

   modport master (
      output in_valid, fmt, op, rs, rt, rd, shamt, funct, imm, target, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, fmt, op, rs, rt, rd, shamt, funct, imm, target, mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_enc_fifo.sv
// Synchronous FIFO for packed instruction words; DEPTH must be a power of two.
module instr_enc_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W:0]   wr_q;
   logic [PTR_W:0]   rd_q;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count = wr_q - rd_q;
   assign full  = (count == (PTR_W + 1)'(DEPTH));
   assign empty = (wr_q == rd_q);
   assign rdata = mem_q[rd_q[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push && !full) wr_q <= wr_q + 1'b1;
         if (pop && !empty) rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem_q[wr_q[PTR_W-1:0]] <= wdata;
   end

endmodule

// File: rtl/instr_encoder.sv
// Packs MIPS fields into R/I/J words, buffers them and streams them to IM at consecutive
// addresses. Define INSTR_ENC_FIELD_CHECK_EN to also reject opcode/format mismatches.
module instr_encoder
   import instr_enc_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk_IE,
   input  logic              rst_IE,
   input  logic              flush,
   instr_encoder_if.slave    bus,
   output logic [ADDR_W:0]   word_count,
   output logic              full,
   output logic              err_fmt
);
   localparam int unsigned       CNT_W        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] BASE         = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_ADDR    = {ADDR_W{1'b1}};
   localparam logic [ADDR_W:0]   REGION_WORDS = {1'b1, {ADDR_W{1'b0}}};

   logic              fifo_full, fifo_empty, fifo_clear;
   logic [CNT_W-1:0]  fifo_count;
   logic [31:0]       packed_word, head;
   logic              hs, bad, push, commit, last_commit;
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   count_q;
   logic              full_q, err_q;

   assign bus.in_ready = !rst_IE && !fifo_full && !full_q && !flush;
   assign hs           = bus.in_valid && bus.in_ready;
   assign packed_word  = pack_word(bus.fmt, bus.op, bus.rs, bus.rt, bus.rd, bus.shamt,
                                   bus.funct, bus.imm, bus.target);

   always_comb begin
      bad = (bus.fmt == FMT_BAD);
`ifdef INSTR_ENC_FIELD_CHECK_EN
      if (bus.fmt == FMT_R && bus.op != OP_RTYPE) bad = 1'b1;
      if (bus.fmt == FMT_J && bus.op != OP_J && bus.op != OP_JAL) bad = 1'b1;
      if (bus.fmt == FMT_I && (bus.op == OP_RTYPE || bus.op == OP_J || bus.op == OP_JAL)) begin
         bad = 1'b1;
      end
`endif
   end

   assign push          = hs && !bad;
   assign bus.mem_we    = !fifo_empty && !full_q;
   assign bus.mem_wdata = bus.mem_we ? head : '0;
   assign bus.mem_addr  = addr_q;
   assign commit        = bus.mem_we && bus.mem_ready && !flush;
   assign last_commit   = commit && (addr_q == LAST_ADDR);
   // Once the region is exhausted any leftover words are dropped.
   assign fifo_clear    = flush || full_q;

   instr_enc_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (clk_IE),
      .rst   (rst_IE),
      .clear (fifo_clear),
      .push  (push),
      .wdata (packed_word),
      .pop   (commit),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (push) state_d = StStream;
         StStream: begin
            if (last_commit) state_d = StDone;
            else if (commit && !push && fifo_count == CNT_W'(1)) state_d = StIdle;
         end
         StDone:   state_d = StDone;
         default:  state_d = StIdle;
      endcase
      if (flush) state_d = StIdle;
   end

   always_ff @(posedge clk_IE) begin
      if (rst_IE || flush) begin
         state_q <= StIdle;
         addr_q  <= BASE;
         count_q <= '0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (hs && bad) err_q <= 1'b1;
         if (commit) begin
            if (last_commit) full_q <= 1'b1;
            else             addr_q <= addr_q + 1'b1;
            if (count_q != REGION_WORDS) count_q <= count_q + 1'b1;
         end
      end
   end

   assign word_count = count_q;
   assign full       = full_q;
   assign err_fmt    = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder with a 4-word region (ADDR_W=2): directed program
// fragments plus randomized episodes checked against an arithmetic reference model.
module tb_instr_encoder;
   import instr_enc_pkg::*;

   localparam int unsigned ADDR_W = 2;
   localparam int unsigned REGION = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic [ADDR_W:0] word_count;
   logic            full;
   logic            err_fmt;

   instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

   instr_encoder #(
      .ADDR_W     (ADDR_W),
      .BASE_ADDR  (0),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_IE     (clk),
      .rst_IE     (rst),
      .flush      (flush),
      .bus        (bus),
      .word_count (word_count),
      .full       (full),
      .err_fmt    (err_fmt)
   );

   always #5 clk = ~clk;

   wr_t         exp_q[$];
   int unsigned acc_idx = 0;
   bit          err_m   = 1'b0;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_word(input int f, input longint unsigned op,
                                            input longint unsigned rs, input longint unsigned rt,
                                            input longint unsigned rd, input longint unsigned sh,
                                            input longint unsigned fn, input longint unsigned imm,
                                            input longint unsigned tgt);
      longint unsigned w;
      case (f)
         0:       w = op * 67108864 + rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn;
         1:       w = op * 67108864 + rs * 2097152 + rt * 65536 + imm;
         default: w = op * 67108864 + tgt;
      endcase
      return w[31:0];
   endfunction

   function automatic bit ref_bad(input int f, input int op);
      bit b;
      b = (f == 3);
`ifdef INSTR_ENC_FIELD_CHECK_EN
      if (f == 0 && op != 0) b = 1'b1;
      if (f == 2 && !(op == 2 || op == 3)) b = 1'b1;
      if (f == 1 && (op == 0 || op == 2 || op == 3)) b = 1'b1;
`endif
      return b;
   endfunction

   task automatic set_fields(input int f, input int op, input int rs, input int rt, input int rd,
                             input int sh, input int fn, input int imm, input int tgt);
      @(posedge clk);
      #2;
      bus.fmt    = fmt_e'(f[1:0]);
      bus.op     = op[5:0];
      bus.rs     = rs[4:0];
      bus.rt     = rt[4:0];
      bus.rd     = rd[4:0];
      bus.shamt  = sh[4:0];
      bus.funct  = fn[5:0];
      bus.imm    = imm[15:0];
      bus.target = tgt[25:0];
   endtask

   // One clock of stimulus; fields must already be on the bus (set_fields consumes the edge).
   task automatic step(input bit v, input bit mr, input bit fl, output bit acc);
      int f;
      bus.in_valid  = v;
      bus.mem_ready = mr;
      flush         = fl;
      @(negedge clk);
      acc = v && bus.in_ready;
      f   = int'(bus.fmt);
      if (fl) begin
         exp_q.delete();
         acc_idx = 0;
         err_m   = 1'b0;
      end else if (acc) begin
         if (ref_bad(f, int'(bus.op))) err_m = 1'b1;
         else begin
            if (acc_idx < REGION) begin
               exp_q.push_back('{addr: ADDR_W'(acc_idx),
                                 data: ref_word(f, bus.op, bus.rs, bus.rt, bus.rd, bus.shamt,
                                                bus.funct, bus.imm, bus.target)});
            end
            acc_idx++;
         end
      end
   endtask

   task automatic idle(input int n, input bit mr);
      bit acc;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
         step(1'b0, mr, 1'b0, acc);
      end
   endtask

   task automatic do_flush();
      bit acc;
      @(posedge clk);
      #2;
      step(1'b0, 1'b0, 1'b1, acc);
   endtask

   task automatic send(input int f, input int op, input int rs, input int rt, input int rd,
                       input int sh, input int fn, input int imm, input int tgt, input bit mr);
      bit acc;
      int tries;
      set_fields(f, op, rs, rt, rd, sh, fn, imm, tgt);
      step(1'b1, mr, 1'b0, acc);
      tries = 1;
      while (!acc && tries < 20) begin
         @(posedge clk);
         #2;
         step(1'b1, mr, 1'b0, acc);
         tries++;
      end
      if (!acc) check("send_accept_timeout", 32'(acc), 32'd1);
   endtask

   // Scoreboard monitor: every committed write must match the head of the expected queue.
   initial begin
      wr_t         e;
      bit          p_stall = 1'b0;
      logic [31:0] p_addr, p_data;
      forever begin
         @(negedge clk);
         if (rst) begin
            p_stall = 1'b0;
            continue;
         end
         if (p_stall) begin
            check("stall_we", 32'(bus.mem_we), 32'd1);
            check("stall_addr", 32'(bus.mem_addr), p_addr);
            check("stall_wdata", bus.mem_wdata, p_data);
         end
         if (bus.mem_we && bus.mem_ready && !flush) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
               check("wr_data", bus.mem_wdata, e.data);
            end
         end
         p_stall = bus.mem_we && !bus.mem_ready && !flush;
         p_addr  = 32'(bus.mem_addr);
         p_data  = bus.mem_wdata;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit acc;
      int f, op;
      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.mem_ready = 1'b0;
      bus.fmt       = FMT_R;
      bus.op        = '0;
      bus.rs        = '0;
      bus.rt        = '0;
      bus.rd        = '0;
      bus.shamt     = '0;
      bus.funct     = '0;
      bus.imm       = '0;
      bus.target    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("rst_word_count", 32'(word_count), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_err_fmt", 32'(err_fmt), 32'd0);

      // add $t2,$t0,$t1
      send(0, 0, 8, 9, 10, 0, 32, 0, 0, 1'b0);
      idle(1, 1'b0);
      check("add_we", 32'(bus.mem_we), 32'd1);
      check("add_addr", 32'(bus.mem_addr), 32'd0);
      check("add_wdata", bus.mem_wdata, 32'h0109_5020);
      idle(1, 1'b1);
      idle(1, 1'b0);
      check("add_count", 32'(word_count), 32'd1);
      check("add_we_after", 32'(bus.mem_we), 32'd0);

      // lw $t0,4($sp) then j 0x0100000
      do_flush();
      send(1, 35, 29, 8, 0, 0, 0, 4, 0, 1'b0);
      send(2, 2, 0, 0, 0, 0, 0, 0, 32'h010_0000, 1'b0);
      idle(1, 1'b0);
      check("lw_addr", 32'(bus.mem_addr), 32'd0);
      check("lw_wdata", bus.mem_wdata, 32'h8FA8_0004);
      idle(1, 1'b1);
      idle(1, 1'b0);
      check("j_addr", 32'(bus.mem_addr), 32'd1);
      check("j_wdata", bus.mem_wdata, 32'h0810_0000);
      idle(2, 1'b1);
      check("lwj_count", 32'(word_count), 32'd2);

      // Backpressure into a full FIFO, then region exhaustion with a fifth word discarded
      do_flush();
      for (int i = 0; i < 4; i++) send(0, 0, i, i + 1, i + 2, i, 32 + i, 0, 0, 1'b0);
      idle(1, 1'b0);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_addr", 32'(bus.mem_addr), 32'd0);
      idle(3, 1'b0);
      send(1, 8, 1, 2, 0, 0, 0, 16'h1234, 0, 1'b1);
      idle(8, 1'b1);
      check("reg_full", 32'(full), 32'd1);
      check("reg_count", 32'(word_count), 32'd4);
      check("reg_mem_we", 32'(bus.mem_we), 32'd0);
      check("reg_addr_hold", 32'(bus.mem_addr), 32'd3);
      check("reg_in_ready", 32'(bus.in_ready), 32'd0);
      set_fields(0, 0, 1, 1, 1, 0, 32, 0, 0);
      step(1'b1, 1'b1, 1'b0, acc);
      check("reg_reject", 32'(acc), 32'd0);
      idle(2, 1'b1);

      // Illegal format, sticky error, flush with words queued
      do_flush();
      send(3, 0, 1, 2, 3, 0, 0, 0, 0, 1'b1);
      idle(1, 1'b1);
      check("bad_err", 32'(err_fmt), 32'd1);
      check("bad_no_we", 32'(bus.mem_we), 32'd0);
      send(0, 0, 4, 5, 6, 0, 36, 0, 0, 1'b0);
      send(2, 3, 0, 0, 0, 0, 0, 0, 26'h3AB_CDEF, 1'b0);
      idle(1, 1'b0);
      check("bad_sticky", 32'(err_fmt), 32'd1);
      do_flush();
      idle(1, 1'b0);
      check("fl_addr", 32'(bus.mem_addr), 32'd0);
      check("fl_count", 32'(word_count), 32'd0);
      check("fl_err", 32'(err_fmt), 32'd0);
      check("fl_we", 32'(bus.mem_we), 32'd0);
      send(1, 43, 29, 31, 0, 0, 0, 16'hFFFC, 0, 1'b0);
      idle(1, 1'b1);
      check("post_fl_addr", 32'(bus.mem_addr), 32'd0);
      check("post_fl_wdata", bus.mem_wdata, 32'hAFBF_FFFC);
      idle(2, 1'b1);

      // R-format with a non-zero opcode
      do_flush();
      send(0, 5, 1, 2, 3, 4, 5, 0, 0, 1'b0);
      idle(1, 1'b0);
`ifdef INSTR_ENC_FIELD_CHECK_EN
      check("rop5_err", 32'(err_fmt), 32'd1);
      check("rop5_we", 32'(bus.mem_we), 32'd0);
`else
      check("rop5_err", 32'(err_fmt), 32'd0);
      check("rop5_op", bus.mem_wdata >> 26, 32'd5);
`endif
      idle(2, 1'b1);

      // Randomized episodes, each drained and checked against the model's counters
      for (int ep = 0; ep < 20; ep++) begin
         do_flush();
         for (int c = 0; c < 25; c++) begin
            f = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) op = int'($urandom_range(0, 63));
            else if (f == 1)               op = $urandom_range(0, 1) ? 35 : 43;
            else if (f == 2)               op = 2 + int'($urandom_range(0, 1));
            else                           op = 0;
            set_fields(f, op, int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                       int'($urandom), int'($urandom), int'($urandom));
            step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, 1'b0, acc);
         end
         idle(8, 1'b1);
         check("ep_count", 32'(word_count), 32'((acc_idx < REGION) ? acc_idx : REGION));
         check("ep_full", 32'(full), 32'(acc_idx >= REGION));
         check("ep_err", 32'(err_fmt), 32'(err_m));
         check("ep_drained", 32'(exp_q.size()), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
